// File: rtl/wdt_multi.sv
// wdt_multi: multi-channel watchdog.
//
// Each heartbeat channel is supervised independently. A channel that sees no
// kick (any edge of its heartbeat) for DELAY_TIME ticks, or a kick that comes
// less than WINDOW_MIN ticks after the previous one, enters BARK: it drives a
// reset pulse of RESET_TIME ticks and latches a sticky cause flag.
//
// Ports:
//   clk            system clock, all logic on rising edge
//   reset          synchronous active-high reset
//   clk_1kHz       slow tick source, each synchronised rising edge is one tick
//   hb             per-channel heartbeat, every edge is a kick
//   ch_en          per-channel enable
//   enable_spi     global enable, ANDed with each ch_en
//   clear_sticky   clears both sticky vectors (a new fault in the same clk wins)
//   wdt_out        per-channel registered reset pulse
//   out            OR of wdt_out
//   sticky_timeout latched timeout cause per channel
//   sticky_early   latched early-kick cause per channel
module wdt_multi #(
  parameter int unsigned      CHANNELS   = 4,
  parameter int unsigned      CNT_W      = 16,
  parameter logic [CNT_W-1:0] DELAY_TIME = 16'd500,
  parameter logic [CNT_W-1:0] RESET_TIME = 16'd50,
  parameter logic [CNT_W-1:0] WINDOW_MIN = 16'd0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_1kHz,
  input  logic [CHANNELS-1:0] hb,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                enable_spi,
  input  logic                clear_sticky,
  output logic [CHANNELS-1:0] wdt_out,
  output logic                out,
  output logic [CHANNELS-1:0] sticky_timeout,
  output logic [CHANNELS-1:0] sticky_early
);

  typedef enum logic [1:0] {StIdle, StRun, StBark} state_e;

  localparam logic [CNT_W-1:0] DELAY_LAST = DELAY_TIME - CNT_W'(1);
  localparam logic [CNT_W-1:0] RESET_LAST = RESET_TIME - CNT_W'(1);

  // Tick synchroniser: [0],[1] are the 2-FF sync, [2] is the edge-detect flop.
  logic [2:0]          r_tick_sync;
  logic [CHANNELS-1:0] r_hb_s1;
  logic [CHANNELS-1:0] r_hb_s2;
  logic [CHANNELS-1:0] r_hb_s3;

  logic                w_tick;
  logic [CHANNELS-1:0] w_kick;
  logic [CHANNELS-1:0] w_en;
  logic [CHANNELS-1:0] w_early;
  logic [CHANNELS-1:0] w_tout;
  logic [CHANNELS-1:0] w_done;
  logic [CHANNELS-1:0] w_bark;

  logic [CHANNELS-1:0] r_wdt;
  logic [CHANNELS-1:0] r_st_tout;
  logic [CHANNELS-1:0] r_st_early;

  // Synchronisers ignore the enables; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_sync <= '0;
      r_hb_s1     <= '0;
      r_hb_s2     <= '0;
      r_hb_s3     <= '0;
    end else begin
      r_tick_sync <= {r_tick_sync[1:0], clk_1kHz};
      r_hb_s1     <= hb;
      r_hb_s2     <= r_hb_s1;
      r_hb_s3     <= r_hb_s2;
    end
  end

  assign w_tick = r_tick_sync[1] & ~r_tick_sync[2];
  assign w_kick = r_hb_s2 ^ r_hb_s3;
  assign w_en   = ch_en & {CHANNELS{enable_spi}};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pulse;
    logic             r_seen;

    // Window is checked against the pre-increment count; the first kick after
    // entering RUN only arms the window (r_seen).
    assign w_early[i] = (r_state == StRun) && w_en[i] && w_kick[i] &&
                        (WINDOW_MIN != '0) && r_seen && (r_cnt < WINDOW_MIN);
    // A kick in the same clk as the deciding tick wins over the timeout.
    assign w_tout[i]  = (r_state == StRun) && w_en[i] && !w_kick[i] && w_tick &&
                        (r_cnt == DELAY_LAST);
    assign w_done[i]  = (r_state == StBark) && w_tick && (r_pulse == RESET_LAST);
    assign w_bark[i]  = (r_state == StBark);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_state <= StIdle;
        r_cnt   <= '0;
        r_pulse <= '0;
        r_seen  <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_en[i]) begin
              r_state <= StRun;
              r_cnt   <= '0;
              r_seen  <= 1'b0;
            end
          end
          StRun: begin
            if (!w_en[i]) begin
              r_state <= StIdle;
            end else if (w_early[i] || w_tout[i]) begin
              r_state <= StBark;
              r_pulse <= '0;
            end else if (w_kick[i]) begin
              r_cnt  <= '0;
              r_seen <= 1'b1;
            end else if (w_tick && (r_cnt != '1)) begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          StBark: begin
            // Kicks and enable are ignored until the pulse has run its length.
            if (w_tick) begin
              if (w_done[i]) begin
                r_pulse <= '0;
                r_cnt   <= '0;
                r_seen  <= 1'b0;
                r_state <= w_en[i] ? StRun : StIdle;
              end else begin
                r_pulse <= r_pulse + CNT_W'(1);
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Outputs track the next state so wdt_out rises in the same clk as BARK entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdt      <= '0;
      r_st_tout  <= '0;
      r_st_early <= '0;
    end else begin
      r_wdt      <= w_early | w_tout | (w_bark & ~w_done);
      r_st_tout  <= (clear_sticky ? '0 : r_st_tout) | w_tout;
      r_st_early <= (clear_sticky ? '0 : r_st_early) | w_early;
    end
  end

  assign wdt_out        = r_wdt;
  assign out            = |r_wdt;
  assign sticky_timeout = r_st_tout;
  assign sticky_early   = r_st_early;

endmodule

// File: tb/tb_wdt_multi.sv
// Directed bench for wdt_multi: 2 channels, DELAY 50, RESET 5, WINDOW 10 ticks,
// one tick every 20 clk.
module tb_wdt_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_1kHz = 1'b0;
  logic       hb0;
  logic       hb1;
  logic [1:0] hb;
  logic [1:0] ch_en;
  logic       enable_spi;
  logic       clear_sticky;
  logic [1:0] wdt_out;
  logic       out;
  logic [1:0] sticky_timeout;
  logic [1:0] sticky_early;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int div = 0;
  int n_rise = 0;
  int last_rise_cyc = 0;
  int hb0_per = 0;
  int wdt0_hits = 0;
  bit mon0 = 1'b0;

  assign hb = {hb1, hb0};

  wdt_multi #(
    .CHANNELS  (2),
    .CNT_W     (16),
    .DELAY_TIME(16'd50),
    .RESET_TIME(16'd5),
    .WINDOW_MIN(16'd10)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_1kHz      (clk_1kHz),
    .hb            (hb),
    .ch_en         (ch_en),
    .enable_spi    (enable_spi),
    .clear_sticky  (clear_sticky),
    .wdt_out       (wdt_out),
    .out           (out),
    .sticky_timeout(sticky_timeout),
    .sticky_early  (sticky_early)
  );

  always #5 clk = ~clk;

  // Slow clock: toggles every 10 clk; remember when each rising edge happened.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div == 9) begin
      div      <= 0;
      clk_1kHz <= ~clk_1kHz;
      if (!clk_1kHz) begin
        n_rise        <= n_rise + 1;
        last_rise_cyc <= cyc + 1;
      end
    end else begin
      div <= div + 1;
    end
  end

  // Channel-0 heartbeat generator, period hb0_per clk per edge (0 = stopped).
  initial begin : hb0_gen
    int cnt = 0;
    hb0 = 1'b0;
    forever begin
      @(negedge clk);
      if (hb0_per != 0) begin
        cnt++;
        if (cnt >= hb0_per) begin
          cnt = 0;
          hb0 = ~hb0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge clk) if (mon0 && wdt_out[0]) wdt0_hits++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_wdt(input int ch, input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wdt_out[ch] === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Leaves the bench half a clk after a slow-clock falling edge, far from ticks.
  task automatic align_fall();
    @(negedge clk_1kHz);
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    int n0;
    int r_at;
    int c0;
    int bad;
    int lag;

    reset = 1'b1;
    enable_spi = 1'b0;
    ch_en = 2'b00;
    hb1 = 1'b0;
    clear_sticky = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_wdt", 32'(wdt_out), 0);
    check_eq("rst_out", 32'(out), 0);
    check_eq("rst_sto", 32'(sticky_timeout), 0);
    check_eq("rst_sen", 32'(sticky_early), 0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("idle_wdt", 32'(wdt_out), 0);

    // Healthy ch0 (kick every 20 ticks) alongside stuck ch1.
    align_fall();
    ch_en = 2'b11;
    enable_spi = 1'b1;
    hb0_per = 400;
    mon0 = 1'b1;
    n0 = n_rise;
    wait_wdt(1, 1'b1, 1200, ok);
    lag = cyc - last_rise_cyc;
    check_eq("stuck_rise", 32'(ok), 1);
    check_eq("stuck_ticks", n_rise - n0, 50);
    check_eq("stuck_lag", 32'((lag >= 2) && (lag <= 5)), 1);
    check_eq("stuck_out", 32'(out), 1);
    check_eq("stuck_sto1", 32'(sticky_timeout[1]), 1);
    check_eq("stuck_sen", 32'(sticky_early), 0);
    r_at = n_rise;
    wait_wdt(1, 1'b0, 200, ok);
    check_eq("stuck_fall", 32'(ok), 1);
    check_eq("stuck_len", n_rise - r_at, 5);
    wait_wdt(1, 1'b1, 1200, ok);
    check_eq("stuck_rise2", 32'(ok), 1);
    check_eq("stuck_period", n_rise - r_at, 55);
    wait_wdt(1, 1'b0, 200, ok);
    check_eq("stuck_fall2", 32'(ok), 1);
    mon0 = 1'b0;
    check_eq("healthy_wdt0", wdt0_hits, 0);
    check_eq("healthy_sto0", 32'(sticky_timeout[0]), 0);
    check_eq("healthy_sen0", 32'(sticky_early[0]), 0);

    // Early kick on ch0: kicks every 5 ticks, second kick faults.
    hb0_per = 0;
    ch_en[0] = 1'b0;
    repeat (50) @(negedge clk);
    align_fall();
    ch_en[0] = 1'b1;
    hb0_per = 100;
    c0 = cyc;
    wait_wdt(0, 1'b1, 400, ok);
    check_eq("early_rise", 32'(ok), 1);
    check_eq("early_when", 32'((cyc - c0 >= 198) && (cyc - c0 <= 208)), 1);
    check_eq("early_sen0", 32'(sticky_early[0]), 1);
    check_eq("early_sto0", 32'(sticky_timeout[0]), 0);
    r_at = n_rise;
    wait_wdt(0, 1'b0, 200, ok);
    check_eq("early_fall", 32'(ok), 1);
    check_eq("early_len", n_rise - r_at, 5);
    hb0_per = 0;
    ch_en[0] = 1'b0;

    // clear_sticky held through ch1's BARK entry: set wins for ch1 only.
    wait_wdt(1, 1'b0, 200, ok);
    check_eq("coll_pre", 32'(ok), 1);
    clear_sticky = 1'b1;
    wait_wdt(1, 1'b1, 1200, ok);
    check_eq("coll_rise", 32'(ok), 1);
    check_eq("coll_sto", 32'(sticky_timeout), 2);
    check_eq("coll_sen", 32'(sticky_early), 0);
    clear_sticky = 1'b0;
    r_at = n_rise;

    // Plain one-clk clear.
    @(negedge clk);
    check_eq("clr_pre", 32'(sticky_timeout), 2);
    clear_sticky = 1'b1;
    @(negedge clk);
    clear_sticky = 1'b0;
    check_eq("clr_sto", 32'(sticky_timeout), 0);
    check_eq("clr_sen", 32'(sticky_early), 0);

    // Global disable mid-pulse: pulse completes, then channel stays quiet.
    repeat (40) @(negedge clk);
    enable_spi = 1'b0;
    wait_wdt(1, 1'b0, 200, ok);
    check_eq("dis_fall", 32'(ok), 1);
    check_eq("dis_len", n_rise - r_at, 5);
    bad = 0;
    repeat (1200) begin
      @(negedge clk);
      if (wdt_out !== 2'b00 || out !== 1'b0) bad++;
    end
    check_eq("dis_quiet", bad, 0);

    // Reset mid-pulse, then a fresh timeout.
    ch_en = 2'b10;
    align_fall();
    enable_spi = 1'b1;
    n0 = n_rise;
    wait_wdt(1, 1'b1, 1200, ok);
    check_eq("rr_rise", 32'(ok), 1);
    check_eq("rr_ticks", n_rise - n0, 50);
    align_fall();
    check_eq("rr_inbark", 32'(wdt_out[1]), 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rr_wdt", 32'(wdt_out), 0);
    check_eq("rr_out", 32'(out), 0);
    check_eq("rr_sticky", 32'({sticky_timeout, sticky_early}), 0);
    reset = 1'b0;
    n0 = n_rise;
    wait_wdt(1, 1'b1, 1200, ok);
    check_eq("rr_rise2", 32'(ok), 1);
    check_eq("rr_ticks2", n_rise - n0, 50);
    check_eq("rr_sto1", 32'(sticky_timeout[1]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
